// File: rtl/seq101_arbiter.sv
// Round-robin shared "101" Mealy detector with per-requester saved context and saturating match counters.
// Build option: define SEQ101_OVERLAP_EN for overlapping detection (default is non-overlapping).
module seq101_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         bit_in,
  input  logic                 clr,
  output logic [N-1:0]         gnt,
  output logic                 found,
  output logic [$clog2(N)-1:0] found_id,
  input  logic [$clog2(N)-1:0] rd_sel,
  output logic [CNT_W-1:0]     rd_cnt
);

  localparam int IDW = $clog2(N);
  localparam int RDN = 2 ** IDW;

  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_ID1   = 2'b01;
  localparam logic [1:0] S_ID10  = 2'b10;

`ifdef SEQ101_OVERLAP_EN
  localparam logic [1:0] S_AFTER_MATCH = S_ID1;
`else
  localparam logic [1:0] S_AFTER_MATCH = S_START;
`endif

  logic [1:0]       r_ctx [N];
  logic [CNT_W-1:0] r_cnt [N];
  logic [IDW-1:0]   r_last;
  logic             r_found_p1;
  logic [IDW-1:0]   r_found_id_p1;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [1:0]       w_cur;
  logic             w_bit;
  logic [1:0]       w_nxt;
  logic             w_match;
  logic [CNT_W-1:0] w_rd [RDN];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin search starting just after the last winner; clr suppresses any grant.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    if (!clr) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(r_last) + k) % N;
        if (!w_any && req[idx]) begin
          w_any = 1'b1;
          w_win = IDW'(idx);
        end
      end
    end
  end

  assign gnt   = w_any ? (N'(1) << w_win) : '0;
  assign w_cur = r_ctx[w_win];
  assign w_bit = bit_in[w_win];

  // Next-state logic for the granted context
  always_comb begin
    w_nxt = S_START;
    case (w_cur)
      S_START: w_nxt = w_bit ? S_ID1 : S_START;
      S_ID1:   w_nxt = w_bit ? S_ID1 : S_ID10;
      S_ID10:  w_nxt = w_bit ? S_AFTER_MATCH : S_START;
      default: w_nxt = S_START;
    endcase
  end

  // Mealy output: match on the "1" that completes 1-0-1
  always_comb begin
    w_match = 1'b0;
    if (w_any && (w_cur == S_ID10) && w_bit)
      w_match = 1'b1;
  end

  // State registers: contexts, counters, pointer and the registered detection pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last        <= IDW'(N - 1);
      r_found_p1    <= 1'b0;
      r_found_id_p1 <= '0;
      for (int i = 0; i < N; i++) begin
        r_ctx[i] <= S_START;
        r_cnt[i] <= '0;
      end
    end else if (clr) begin
      r_found_p1    <= 1'b0;
      r_found_id_p1 <= '0;
      for (int i = 0; i < N; i++) begin
        r_ctx[i] <= S_START;
        r_cnt[i] <= '0;
      end
    end else begin
      r_found_p1    <= w_match;
      r_found_id_p1 <= w_match ? w_win : '0;
      if (w_any) begin
        r_last       <= w_win;
        r_ctx[w_win] <= w_nxt;
        if (w_match)
          r_cnt[w_win] <= sat_inc(r_cnt[w_win]);
      end
    end
  end

  assign found    = r_found_p1;
  assign found_id = r_found_id_p1;

  // Readout table padded to a power of two so out-of-range selects read zero
  always_comb begin
    for (int i = 0; i < RDN; i++) begin
      w_rd[i] = '0;
      if (i < N)
        w_rd[i] = r_cnt[i];
    end
  end

  assign rd_cnt = w_rd[rd_sel];

endmodule

// File: tb/tb_seq101_arbiter.sv
// Directed bench for seq101_arbiter (N=4, CNT_W=8); expectations follow SEQ101_OVERLAP_EN when defined.
module tb_seq101_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic       clr;
  logic [3:0] gnt;
  logic       found;
  logic [1:0] found_id;
  logic [1:0] rd_sel;
  logic [7:0] rd_cnt;

  int checks = 0;
  int errors = 0;

  seq101_arbiter #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr(clr),
    .gnt(gnt), .found(found), .found_id(found_id), .rd_sel(rd_sel), .rd_cnt(rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    rd_sel = sel;
    #1;
    chk(tag, rd_cnt, exp);
  endtask

  logic [3:0] rr_g   [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                              4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0001};
  logic [3:0] iso_g  [7]  = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] iso_b  [7]  = '{4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
  logic       iso_f  [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] iso_id [7]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
  logic [6:0] ov_bits;
  logic [6:0] ov_exp;
  logic [7:0] ov_cnt;

  initial begin
    reset = 1'b0; req = 4'b0000; bit_in = 4'b0000; clr = 1'b0; rd_sel = 2'd0;
    ov_bits = 7'b0010101;
`ifdef SEQ101_OVERLAP_EN
    ov_exp = 7'b0010100; ov_cnt = 8'd2;
`else
    ov_exp = 7'b0000100; ov_cnt = 8'd1;
`endif

    // Reset state
    tick(); tick();
    chk("rst_found", found, 1'b0);
    chk("rst_found_id", found_id, 2'd0);
    for (int i = 0; i < 4; i++) chk_cnt("rst_cnt", 2'(i), 8'd0);
    req = 4'b1111; #1;
    chk("rst_gnt_first", gnt, 4'b0001);
    req = 4'b0000;
    @(posedge clk); #1 reset = 1'b1;

    // Round-robin rotation, then sparse request pattern
    for (int i = 0; i < 11; i++) begin
      req = (i < 8) ? 4'b1111 : 4'b0101;
      #1;
      chk("rr_gnt", gnt, rr_g[i]);
      tick();
      chk("rr_nofound", found, 1'b0);
    end
    req = 4'b0000; #1;
    chk("idle_gnt", gnt, 4'b0000);
    tick();

    // Overlap / non-overlap stream on requester 0
    req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      bit_in = {3'b000, ov_bits[i]};
      #1;
      chk("ov_gnt", gnt, 4'b0001);
      tick();
      chk("ov_found", found, ov_exp[i]);
      chk("ov_found_id", found_id, 2'd0);
    end
    req = 4'b0000; bit_in = 4'b0000;
    chk_cnt("ov_cnt", 2'd0, ov_cnt);

    // Clear wipes counters, blocks grants, keeps pointer
    clr = 1'b1; req = 4'b1111; #1;
    chk("clr_gnt", gnt, 4'b0000);
    tick();
    clr = 1'b0; req = 4'b0000;
    chk_cnt("clr_cnt0", 2'd0, 8'd0);

    // Context isolation between requesters 0 and 1
    req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      bit_in = iso_b[i];
      #1;
      chk("iso_gnt", gnt, iso_g[i]);
      tick();
      chk("iso_found", found, iso_f[i]);
      chk("iso_found_id", found_id, iso_id[i]);
    end
    req = 4'b0000; bit_in = 4'b0000;
    tick();
    chk("iso_found_drop", found, 1'b0);
    chk_cnt("iso_cnt0", 2'd0, 8'd1);
    chk_cnt("iso_cnt1", 2'd1, 8'd1);
    chk_cnt("iso_cnt2", 2'd2, 8'd0);

    // Clear colliding with a completing match on requester 0
    req = 4'b0001;
    bit_in = 4'b0001; tick();
    bit_in = 4'b0000; tick();
    bit_in = 4'b0001; clr = 1'b1; #1;
    chk("col_gnt", gnt, 4'b0000);
    tick();
    clr = 1'b0;
    chk("col_found", found, 1'b0);
    chk_cnt("col_cnt0", 2'd0, 8'd0);
    chk_cnt("col_cnt1", 2'd1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      bit_in = (i == 1) ? 4'b0000 : 4'b0001;
      tick();
      chk("col_refound", found, (i == 2) ? 1'b1 : 1'b0);
    end
    chk_cnt("col_recnt", 2'd0, 8'd1);

    // Saturation on requester 2
    req = 4'b0100; rd_sel = 2'd2;
    for (int r = 0; r < 300; r++) begin
      for (int j = 0; j < 3; j++) begin
        bit_in = (j == 1) ? 4'b0000 : 4'b0100;
        tick();
      end
      chk("sat_found", found, 1'b1);
      chk("sat_found_id", found_id, 2'd2);
      if (r == 0)   chk("sat_cnt_first", rd_cnt, 8'd1);
      if (r == 254) chk("sat_cnt_254", rd_cnt, 8'd255);
      if (r == 255) chk("sat_cnt_255", rd_cnt, 8'd255);
    end
    chk("sat_cnt_end", rd_cnt, 8'd255);

    // Reset mid-stream on requester 1
    req = 4'b0010;
    bit_in = 4'b0010; tick();
    bit_in = 4'b0000; tick();
    req = 4'b0000;
    reset = 1'b0; #1;
    chk("mrst_cnt_async", rd_cnt, 8'd0);
    chk("mrst_found", found, 1'b0);
    tick(); tick(); tick();
    chk_cnt("mrst_cnt0", 2'd0, 8'd0);
    reset = 1'b1;
    req = 4'b1111; bit_in = 4'b0010; #1;
    chk("mrst_gnt_first", gnt, 4'b0001);
    tick();
    #1;
    chk("mrst_gnt_second", gnt, 4'b0010);
    tick();
    chk("mrst_nofound", found, 1'b0);
    req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq101_arbiter.md
# seq101_arbiter

Shares one Mealy "101" serial sequence-detector datapath among N requesters. Each requester gets its own saved detector state. Each cycle a round-robin arbiter grants one requester and consumes one bit from it. A detection produces a registered pulse tagged with the requester id and bumps that requester's saturating match counter. The block sits between the serial-input channels and the status/readout logic of the Guia 11 detector work.

## Interface
- `N`, default 4: number of requesters (2..8).
- `CNT_W`, default 8: width of each per-requester match counter.
- `clk` input 1: clock, all state updated on posedge.
- `reset` input 1: reset, asynchronous, active-low.
- `req` input N: request vector; bit i high means requester i presents a valid bit.
- `bit_in` input N: serial data; bit i is requester i's current bit, sampled only when granted.
- `clr` input 1: synchronous clear of all contexts and counters.
- `gnt` output N: one-hot grant (all zero if no grant), combinational from `req`, `clr` and the pointer.
- `found` output 1: registered one-cycle pulse, "101" completed.
- `found_id` output clog2(N): requester index for `found`; 0 when `found` is low.
- `rd_sel` input clog2(N): counter readout select.
- `rd_cnt` output CNT_W: combinational readout of counter `rd_sel`.

## Operation
- Per-requester 2-bit context, encoding `start`=00, `id1`=01, `id10`=10; 11 is illegal.
- Transitions for the granted requester with bit b:
  - `start`: b=1 → `id1`, b=0 → `start`.
  - `id1`: b=1 → `id1`, b=0 → `id10`.
  - `id10`: b=0 → `start`. b=1 → match, next state set by configuration.
  - Illegal 11 → `start`, no match.
- Non-granted contexts hold their value.
- Arbiter: round-robin pointer `last` holds the last granted index. Search runs `last+1`, `last+2`, … mod N; the first with `req` high wins. `last` updates to the winner on a granted cycle and holds otherwise.
- On a match, at the same edge:
  - `found`←1 and `found_id`←winner index.
  - The winner's counter increments, saturating at 2^CNT_W−1 (no wrap).
- `clr` high:
  - `gnt`=0 that cycle and no bit is consumed.
  - All contexts go to `start`, all counters go to 0, `found`←0.
  - `last` is unchanged.
  - `clr` overrides a coincident match.
- `rd_sel` ≥ N gives `rd_cnt`=0.

## Timing
- Reset (reset=0, asynchronous) values:
  - Contexts = `start`, counters = 0, `found`=0, `found_id`=0.
  - `last`=N−1, so requester 0 has first priority.
  - `gnt` resolves from `req` immediately.
- Asserting reset mid-stream discards partial sequences. After release, the first grant goes to the lowest requesting index.
- Grant and bit consumption happen in the same cycle (cycle k). `found` and `found_id` are valid in cycle k+1 for exactly one cycle.
- `rd_cnt` shows the incremented count from cycle k+1, aligned with `found`.
- Throughput is one bit per cycle total. With all N requesting, each requester advances once every N cycles.
- `req` low: that requester's context is frozen. Sequences may span arbitrary idle gaps.
- `req`=0 gives `gnt`=0, `found`←0 next cycle, and `last` holds.

## Configuration
- `SEQ101_OVERLAP_EN` defined: overlapping detection. On a match the next state is `id1`, so "10101" yields 2 matches.
- Undefined: non-overlapping detection. On a match the next state is `start`, so "10101" yields 1 match. Every other behaviour is identical.

## Test plan
- Overlap stream: N=4, only `req`[0] held high, bits 1,0,1,0,1,0,0.
  - With `SEQ101_OVERLAP_EN`: `found` pulses after the 3rd and 5th bits with `found_id`=0; `rd_cnt`(sel 0)=2.
  - Without it: a single pulse after the 3rd bit; count=1.
- Round-robin rotation: `req`=4'b1111 for 8 cycles after reset → `gnt` = 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000. Then `req`=4'b0101 → 0001, 0100, 0001.
- Context isolation: `req`=4'b0011, requester 0 streams 1,0,1 and requester 1 streams 1,1,0,1, interleaved by the arbiter → requester 0 reports `found_id`=0 on its 3rd grant, requester 1 reports `found_id`=1 on its 4th. No cross-talk; each counter ends at 1.
- Saturation: CNT_W=8, requester 2 alone streams 300 repetitions of "101" (non-overlap build) → counter reads 255 and stays 255; `found` still pulses each match.
- `clr` collision: `clr` asserted in the cycle requester 0 completes "101" → `gnt`=0 that cycle, no `found`, all counters read 0. A following 1,0,1 on requester 0 produces exactly one match.
- Reset mid-operation: requester 1 has consumed 1,0. `reset` pulsed low for 3 cycles → `found`=0 and counters 0. After release with `req`=4'b1111, the first `gnt`=0001. Requester 1 then sending 1 produces no match (context was cleared).
